// File: rtl/eth_udp_defs.sv
// Shared constants, state encoding and byte helper for the GMII/UDP receive
// and transmit paths.
package eth_udp_defs;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hd5;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;

    localparam logic [31:0] CRC_INIT      = 32'hffffffff;
    localparam logic [31:0] CRC_RESIDUE   = 32'hc704dd7b;

    localparam logic [4:0]  ETH_HDR_LEN   = 5'd14;
    localparam logic [4:0]  IP_HDR_LEN    = 5'd20;
    localparam logic [4:0]  UDP_HDR_LEN   = 5'd8;
    localparam logic [4:0]  PREAMBLE_MAX  = 5'd7;

    typedef enum logic [3:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        TAIL,
        DROP
    } rx_state_t;

    // Byte idx counted from the most significant end of a 48-bit field.
    function automatic logic [7:0] msb_byte(input logic [47:0] v, input logic [2:0] idx);
        logic [47:0] t;
        t = v << {idx, 3'b000};
        return t[47:40];
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-parallel Ethernet CRC-32. Data bits enter LSB first into an MSB-first
// register, so the register is the bit-reverse of the usual reflected form.
module crc32_d8
    import eth_udp_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04c11db7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       crc <= CRC_INIT;
        else if (init) crc <= CRC_INIT;
        else if (en)   crc <= crc_next(crc, data);
    end

endmodule

// File: rtl/eth_udp_rx_gmii.sv
// GMII receive path: strips preamble/Ethernet/IPv4/UDP headers, filters on
// local MAC/IP/port and streams the UDP payload with a CRC-checked done pulse.
module eth_udp_rx_gmii
    import eth_udp_defs::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h000a3501fec0,
    parameter logic [31:0] LOCAL_IP   = 32'hc0a80002,
    parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rx_data,
    output logic        rx_data_valid,
    output logic [7:0]  rx_data,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic [15:0] rx_byte_num,
    output logic [31:0] rx_src_ip,
    output logic [15:0] rx_src_port,
    output logic        rx_done,
    output logic        rx_err
);

    rx_state_t   state, state_next;
    logic [4:0]  cnt;
    logic [15:0] pay_cnt;
    logic        mac_ok, bc_ok, mac_hit, bc_hit;
    logic [31:0] ip_sh;
    logic [15:0] port_sh, len_sh, udp_len;
    logic [7:0]  mac_byte, ip_byte, port_byte;
    logic        pay_last, crc_init, crc_en;
    logic [31:0] crc;

    assign mac_byte  = msb_byte(LOCAL_MAC, cnt[2:0]);
    assign ip_byte   = msb_byte({LOCAL_IP, 16'h0000}, {1'b0, cnt[1:0]});
    assign port_byte = msb_byte({LOCAL_PORT, 32'h0000_0000}, {2'b00, cnt[0]});

    // Unicast and broadcast matches are tracked separately so a mixed address fails.
    assign mac_hit  = (cnt == 5'd0 || mac_ok) && gmii_rx_data == mac_byte;
    assign bc_hit   = (cnt == 5'd0 || bc_ok)  && gmii_rx_data == 8'hff;
    assign udp_len  = {len_sh[7:0], gmii_rx_data};
    assign pay_last = pay_cnt == rx_byte_num - 16'd1;

    assign crc_init = state == PREAMBLE && gmii_rx_dv && gmii_rx_data == SFD_BYTE;
    assign crc_en   = gmii_rx_dv && (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL});

    crc32_d8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (gmii_rx_data),
        .crc  (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_IDLE: if (!gmii_rx_dv) state_next = IDLE;
            IDLE: begin
                if (gmii_rx_dv)
                    state_next = (gmii_rx_data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!gmii_rx_dv)                      state_next = IDLE;
                else if (gmii_rx_data == SFD_BYTE)    state_next = ETH_HDR;
                else if (gmii_rx_data != PREAMBLE_BYTE || cnt >= PREAMBLE_MAX)
                                                      state_next = DROP;
            end
            ETH_HDR: begin
                if (!gmii_rx_dv)
                    state_next = IDLE;
                else if ((cnt < 5'd6 && !mac_hit && !bc_hit) ||
                         (cnt == 5'd12 && gmii_rx_data != ETH_TYPE_IPV4[15:8]) ||
                         (cnt == 5'd13 && gmii_rx_data != ETH_TYPE_IPV4[7:0]))
                    state_next = DROP;
                else if (cnt == ETH_HDR_LEN - 5'd1)
                    state_next = IP_HDR;
            end
            IP_HDR: begin
                if (!gmii_rx_dv)
                    state_next = IDLE;
                else if ((cnt == 5'd0 && gmii_rx_data != IP_VER_IHL) ||
                         (cnt == 5'd9 && gmii_rx_data != IP_PROTO_UDP) ||
                         (cnt >= 5'd16 && gmii_rx_data != ip_byte))
                    state_next = DROP;
                else if (cnt == IP_HDR_LEN - 5'd1)
                    state_next = UDP_HDR;
            end
            UDP_HDR: begin
                if (!gmii_rx_dv)
                    state_next = IDLE;
                else if (((cnt == 5'd2 || cnt == 5'd3) && gmii_rx_data != port_byte) ||
                         (cnt == 5'd5 && udp_len < 16'd8))
                    state_next = DROP;
                else if (cnt == UDP_HDR_LEN - 5'd1)
                    state_next = (len_sh > 16'd8) ? PAYLOAD : TAIL;
            end
            PAYLOAD: begin
                if (!gmii_rx_dv)   state_next = IDLE;
                else if (pay_last) state_next = TAIL;
            end
            TAIL:    if (!gmii_rx_dv) state_next = IDLE;
            DROP:    if (!gmii_rx_dv) state_next = IDLE;
            default: state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            pay_cnt       <= '0;
            mac_ok        <= 1'b0;
            bc_ok         <= 1'b0;
            ip_sh         <= '0;
            port_sh       <= '0;
            len_sh        <= '0;
            rx_data_valid <= 1'b0;
            rx_data       <= '0;
            rx_sop        <= 1'b0;
            rx_eop        <= 1'b0;
            rx_byte_num   <= '0;
            rx_src_ip     <= '0;
            rx_src_port   <= '0;
            rx_done       <= 1'b0;
            rx_err        <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            rx_sop        <= 1'b0;
            rx_eop        <= 1'b0;
            rx_done       <= 1'b0;
            rx_err        <= 1'b0;

            // IDLE->PREAMBLE has already consumed the first 0x55.
            if (state_next != state)
                cnt <= (state_next == PREAMBLE) ? 5'd1 : 5'd0;
            else if (state inside {PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR})
                cnt <= cnt + 5'd1;

            case (state)
                ETH_HDR: begin
                    if (gmii_rx_dv && cnt < 5'd6) begin
                        mac_ok <= mac_hit;
                        bc_ok  <= bc_hit;
                    end
                end
                IP_HDR: begin
                    if (gmii_rx_dv && cnt >= 5'd12 && cnt <= 5'd15)
                        ip_sh <= {ip_sh[23:0], gmii_rx_data};
                end
                UDP_HDR: begin
                    if (gmii_rx_dv) begin
                        if (cnt <= 5'd1)
                            port_sh <= {port_sh[7:0], gmii_rx_data};
                        if (cnt == 5'd4 || cnt == 5'd5)
                            len_sh <= {len_sh[7:0], gmii_rx_data};
                        if (cnt == UDP_HDR_LEN - 5'd1) begin
                            rx_src_ip   <= ip_sh;
                            rx_src_port <= port_sh;
                            rx_byte_num <= len_sh - 16'd8;
                            pay_cnt     <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (gmii_rx_dv) begin
                        rx_data_valid <= 1'b1;
                        rx_data       <= gmii_rx_data;
                        rx_sop        <= pay_cnt == 16'd0;
                        rx_eop        <= pay_last;
                        pay_cnt       <= pay_cnt + 16'd1;
                    end else begin
                        rx_done <= 1'b1;
                        rx_err  <= 1'b1;
                    end
                end
                TAIL: begin
                    if (!gmii_rx_dv) begin
                        rx_done <= 1'b1;
                        rx_err  <= crc != CRC_RESIDUE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
